// File: rtl/ecc_scrub_reader_if.sv
// RAM-port bundle between the ECC scrubber (master) and one port of the
// SECDED-protected RAM (slave).
interface ecc_scrub_reader_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int CW_WIDTH   = 13
);
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [CW_WIDTH-1:0]   mem_wdata;
  logic [CW_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ecc_scrub_reader.sv
// SECDED scrubber: walks every RAM address once per pass, writes back
// single-bit corrections and logs/counts double-bit errors.
module ecc_scrub_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int PARITY_BITS = 4,
  parameter int CW_WIDTH    = DATA_WIDTH + PARITY_BITS + 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  ecc_scrub_reader_if.master    m_mem,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_sec_count,
  output logic [CNT_WIDTH-1:0]  o_ded_count,
  output logic                  o_ded_flag,
  output logic [ADDR_WIDTH-1:0] o_ded_addr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int                    POS_LIMIT = DATA_WIDTH + PARITY_BITS + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  function automatic logic [PARITY_BITS-1:0] syndrome(input logic [CW_WIDTH-1:0] cw);
    logic [PARITY_BITS-1:0] s;
    s = '0;
    for (int i = 1; i < CW_WIDTH; i++) begin
      if (cw[i]) s = s ^ i[PARITY_BITS-1:0];
    end
    return s;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_abort;
  logic                   r_busy;
  logic                   r_done;
  logic [CNT_WIDTH-1:0]   r_sec;
  logic [CNT_WIDTH-1:0]   r_ded;
  logic                   r_flag;
  logic [ADDR_WIDTH-1:0]  r_ded_addr;
  logic [CW_WIDTH-1:0]    r_wdata;
  logic [CW_WIDTH-1:0]    r_cw_p1;

  logic [PARITY_BITS-1:0] w_syn;
  logic                   w_pa;
  logic                   w_sec;
  logic                   w_ded;
  logic                   w_last;
  logic [CW_WIDTH-1:0]    w_fixed;

  // stage p1: codeword captured from the RAM one cycle after the read
  always_ff @(posedge clk) begin
    if (r_state == S_WAIT) r_cw_p1 <= m_mem.mem_rdata;
  end

  // syndrome 0 with odd parity flips bit 0; syndromes past the top bit are uncorrectable
  always_comb begin
    w_syn   = syndrome(r_cw_p1);
    w_pa    = ^r_cw_p1;
    w_sec   = w_pa && (int'(w_syn) < POS_LIMIT);
    w_ded   = w_pa ? !w_sec : (w_syn != '0);
    w_fixed = r_cw_p1 ^ (CW_WIDTH'(1) << w_syn);
    w_last  = (r_addr == LAST_ADDR) || r_abort || i_abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_abort    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sec      <= '0;
      r_ded      <= '0;
      r_flag     <= 1'b0;
      r_ded_addr <= '0;
      r_wdata    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_RD;
            r_addr     <= '0;
            r_abort    <= 1'b0;
            r_busy     <= 1'b1;
            r_sec      <= '0;
            r_ded      <= '0;
            r_flag     <= 1'b0;
            r_ded_addr <= '0;
          end
        end
        S_RD: begin
          r_abort <= r_abort | i_abort;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_abort <= r_abort | i_abort;
          r_state <= S_CHK;
        end
        S_CHK: begin
          r_abort <= r_abort | i_abort;
          if (w_sec) begin
            r_sec   <= sat_inc(r_sec);
            r_wdata <= w_fixed;
            r_state <= S_WB;
          end else begin
            if (w_ded) begin
              r_ded <= sat_inc(r_ded);
              if (!r_flag) begin
                r_flag     <= 1'b1;
                r_ded_addr <= r_addr;
              end
            end
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_abort <= 1'b0;
              r_state <= S_RD;
            end
          end
        end
        S_WB: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_abort <= 1'b0;
            r_state <= S_RD;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_mem.mem_en    = (r_state == S_RD) || (r_state == S_WB);
  assign m_mem.mem_we    = (r_state == S_WB);
  assign m_mem.mem_addr  = r_addr;
  assign m_mem.mem_wdata = r_wdata;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sec_count = r_sec;
  assign o_ded_count = r_ded;
  assign o_ded_flag  = r_flag;
  assign o_ded_addr  = r_ded_addr;

endmodule

// File: tb/tb_ecc_scrub_reader.sv
// Bench for ecc_scrub_reader: behavioural RAM, table of scrub passes with a
// brute-force SECDED reference and a read/write scoreboard, plus a reset-in-WB sequence.
module tb_ecc_scrub_reader;
  localparam int AW    = 3;
  localparam int CW    = 13;
  localparam int CNTW  = 3;
  localparam int DEPTH = 8;
  localparam logic [CW-1:0] CLEAN = 13'h144E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic o_busy, o_done, o_flag;
  logic [CNTW-1:0] sec, ded;
  logic [AW-1:0]   daddr;

  ecc_scrub_reader_if #(.ADDR_WIDTH(AW), .CW_WIDTH(CW)) bus ();

  ecc_scrub_reader #(.CNT_WIDTH(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_abort     (abort),
    .m_mem       (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_sec_count (sec),
    .o_ded_count (ded),
    .o_ded_flag  (o_flag),
    .o_ded_addr  (daddr)
  );

  always #5 clk = ~clk;

  logic [CW-1:0]       ram [DEPTH];
  logic                load_en = 1'b0;
  logic [DEPTH*CW-1:0] load_img = '0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= load_img[i*CW +: CW];
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    logic [DEPTH*CW-1:0] img;
    bit keep;
    int abort_at;
    bit start_abort;
    bit mid_start;
    int e_sec;
    int e_ded;
    bit e_flag;
    int e_daddr;
    int e_cyc;
  } vec_t;

  vec_t vt[11];
  int n_vec = 0;
  int n_miss = 0;
  int exp_rd[$];
  logic [AW+CW-1:0] exp_wr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  function automatic logic [CW-1:0] enc(input logic [7:0] d);
    logic [CW-1:0] c;
    int k;
    logic b;
    c = '0;
    k = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int q = 1; q < CW; q = q * 2) begin
      b = 1'b0;
      for (int p = 1; p < CW; p++) if (p != q && (p & q) != 0) b ^= c[p];
      c[q] = b;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [7:0] dext(input logic [CW-1:0] cw);
    logic [7:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[p];
        k++;
      end
    end
    return d;
  endfunction

  function automatic bit is_valid(input logic [CW-1:0] cw);
    return enc(dext(cw)) == cw;
  endfunction

  // kind: 0 clean, 1 correctable (fixed = nearest codeword), 2 uncorrectable
  task automatic classify(input logic [CW-1:0] cw, output int kind, output logic [CW-1:0] fixed);
    logic [CW-1:0] t;
    fixed = cw;
    kind  = 2;
    if (is_valid(cw)) kind = 0;
    else begin
      for (int b = 0; b < CW; b++) begin
        t = cw ^ (CW'(1) << b);
        if (kind == 2 && is_valid(t)) begin
          kind  = 1;
          fixed = t;
        end
      end
    end
  endtask

  function automatic logic [DEPTH*CW-1:0] mkimg(input logic [CW-1:0] base, input int a1,
                                                input logic [CW-1:0] v1, input int a2,
                                                input logic [CW-1:0] v2);
    logic [DEPTH*CW-1:0] img;
    for (int i = 0; i < DEPTH; i++) img[i*CW +: CW] = base;
    if (a1 >= 0) img[a1*CW +: CW] = v1;
    if (a2 >= 0) img[a2*CW +: CW] = v2;
    return img;
  endfunction

  task automatic set_vec(input int idx, input logic [DEPTH*CW-1:0] img, input bit keep,
                         input int abort_at, input bit sa, input bit ms, input int es,
                         input int ed, input bit ef, input int eda, input int ec);
    vt[idx].img = img;       vt[idx].keep = keep;     vt[idx].abort_at = abort_at;
    vt[idx].start_abort = sa; vt[idx].mid_start = ms; vt[idx].e_sec = es;
    vt[idx].e_ded = ed;      vt[idx].e_flag = ef;     vt[idx].e_daddr = eda;
    vt[idx].e_cyc = ec;
  endtask

  task automatic load(input logic [DEPTH*CW-1:0] img);
    @(negedge clk);
    load_img = img;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [CW-1:0] expimg [DEPTH];
    logic [CW-1:0] f;
    int kind, last, cyc;
    bit got;
    if (!v.keep) load(v.img);
    last = (v.abort_at >= 0) ? v.abort_at : DEPTH - 1;
    exp_rd.delete();
    exp_wr.delete();
    for (int a = 0; a < DEPTH; a++) begin
      expimg[a] = ram[a];
      if (a <= last) begin
        exp_rd.push_back(a);
        classify(ram[a], kind, f);
        if (kind == 1) begin
          exp_wr.push_back({a[AW-1:0], f});
          expimg[a] = f;
        end
      end
    end
    @(negedge clk);
    start = 1'b1;
    abort = v.start_abort;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 80) begin
      @(negedge clk);
      abort = 1'b0;
      start = v.mid_start && (cyc == 10);
      if (cyc == 0) chk("busy_after_start", 32'(o_busy), 32'd1);
      if (bus.mem_en) begin
        if (bus.mem_we) begin
          if (exp_wr.size() == 0) fail_now("unexpected_write");
          else chk("writeback", 32'({bus.mem_addr, bus.mem_wdata}), 32'(exp_wr.pop_front()));
        end else begin
          if (exp_rd.size() == 0) fail_now("unexpected_read");
          else chk("read_addr", 32'(bus.mem_addr), 32'(exp_rd.pop_front()));
          if (int'(bus.mem_addr) == v.abort_at) abort = 1'b1;
        end
      end
      if (o_done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("done_latency", 32'(cyc), 32'(v.e_cyc));
    chk("busy_with_done", 32'(o_busy), 32'd0);
    chk("reads_missing", 32'(exp_rd.size()), 32'd0);
    chk("writes_missing", 32'(exp_wr.size()), 32'd0);
    chk("sec_count", 32'(sec), 32'(v.e_sec));
    chk("ded_count", 32'(ded), 32'(v.e_ded));
    chk("ded_flag", 32'(o_flag), 32'(v.e_flag));
    chk("ded_addr", 32'(daddr), 32'(v.e_daddr));
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("counts_hold", 32'({sec, ded}), 32'({v.e_sec[CNTW-1:0], v.e_ded[CNTW-1:0]}));
    for (int a = 0; a < DEPTH; a++) chk("ram_after_pass", 32'(ram[a]), 32'(expimg[a]));
  endtask

  logic [29:0] outs;
  always_comb outs = {o_busy, o_done, o_flag, sec, ded, daddr,
                      bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};

  initial begin
    logic [DEPTH*CW-1:0] img;
    bit seen;

    set_vec(0, mkimg(CLEAN, -1, '0, -1, '0), 1'b0, -1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 25);
    set_vec(1, mkimg(CLEAN, 2, 13'h140E, -1, '0), 1'b0, -1, 1'b0, 1'b0, 1, 0, 1'b0, 0, 26);
    set_vec(2, '0, 1'b1, -1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 25);
    set_vec(3, mkimg(CLEAN, 5, 13'h144F, -1, '0), 1'b0, -1, 1'b0, 1'b0, 1, 0, 1'b0, 0, 26);
    set_vec(4, mkimg(CLEAN, 3, 13'h100E, 6, 13'h100E), 1'b0, -1, 1'b0, 1'b0, 0, 2, 1'b1, 3, 25);
    set_vec(5, mkimg(CLEAN, 2, 13'h140E, -1, '0), 1'b0, 1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 7);
    set_vec(6, mkimg(CLEAN, -1, '0, -1, '0), 1'b0, -1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 25);
    set_vec(7, mkimg(13'h100E, -1, '0, -1, '0), 1'b0, -1, 1'b0, 1'b0, 0, 7, 1'b1, 0, 25);
    for (int i = 0; i < DEPTH; i++)
      img[i*CW +: CW] = enc(8'(i * 37)) ^ (CW'(1) << ((i * 5) % 13));
    set_vec(8, img, 1'b0, -1, 1'b0, 1'b0, 7, 0, 1'b0, 0, 33);
    img = mkimg(CLEAN, 0, 13'h044E, 4, 13'h0448);
    img[6*CW +: CW] = 13'h100E;
    set_vec(9, img, 1'b0, -1, 1'b0, 1'b1, 1, 2, 1'b1, 4, 26);
    set_vec(10, '0, 1'b1, -1, 1'b0, 1'b0, 1, 0, 1'b0, 0, 26);

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(outs), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // reset during the write-back of address 4
    load(mkimg(CLEAN, 4, 13'h140E, -1, '0));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_en && bus.mem_we) seen = 1'b1;
    end
    if (!seen) fail_now("wb_before_reset");
    chk("wb_addr_before_reset", 32'(bus.mem_addr), 32'd4);
    rst = 1'b1;
    #1 chk("outputs_at_reset", 32'(outs), 32'd0);
    @(posedge clk);
    #1 chk("no_write_after_reset", 32'(ram[4]), 32'(13'h140E));
    @(negedge clk);
    rst = 1'b0;
    run_vec(vt[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ecc_scrub_reader.md
Name: ecc_scrub_reader

Overview:
- Read-side companion to the ECC-protected true-dual-port RAM. It owns one RAM port and decodes the SECDED codewords written through the encoder side.
- Each pass walks every address, checks each codeword, and writes back the corrected codeword on a single-bit error.
- Double-bit errors are flagged and counted, and the address of the first one is logged.
- Software or a sequencer starts each pass and reads the counters when it finishes.

Parameters:
- DATA_WIDTH, 8, payload bits per word.
- ADDR_WIDTH, 3, RAM address bits; DEPTH = 2**ADDR_WIDTH.
- PARITY_BITS, 4, Hamming check bits; must satisfy 2**PARITY_BITS >= DATA_WIDTH+PARITY_BITS+1.
- CW_WIDTH, DATA_WIDTH+PARITY_BITS+1, stored codeword width (13 by default).
- CNT_WIDTH, 16, width of the error counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a pass; ignored while busy.
- abort  in  1  ends the pass at the next address boundary.
- mem_en  out  1  RAM port enable.
- mem_we  out  1  RAM port write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  CW_WIDTH  corrected codeword for write-back.
- mem_rdata  in  CW_WIDTH  RAM read data, valid 1 cycle after mem_en with mem_we=0.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when a pass ends, whether completed or aborted.
- sec_count  out  CNT_WIDTH  corrected single-bit errors in the current/last pass; saturates.
- ded_count  out  CNT_WIDTH  uncorrectable errors; saturates.
- ded_flag  out  1  sticky; set on the first DED and cleared on start.
- ded_addr  out  ADDR_WIDTH  address of the first DED in the pass.

Behaviour:
- Codeword layout:
  - bit 0 is overall even parity over bits 1..CW_WIDTH-1.
  - Bits at power-of-two positions (1, 2, 4, 8) are Hamming check bits; check bit p covers every position with bit p set.
  - Data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12, in order.
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-pass abandons the pass immediately; no write is issued after reset asserts.
- FSM states: IDLE, RD, WAIT, CHK, WB, DONE.
  - IDLE: on start, clear the counters, ded_flag and ded_addr; set addr=0; go to RD.
  - RD: mem_en=1, mem_we=0, mem_addr=addr; go to WAIT.
  - WAIT: latch mem_rdata at the end of this cycle; go to CHK.
  - CHK: compute the syndrome s (XOR of the positions of set bits 1..CW_WIDTH-1) and the overall parity pa.
    - s=0, pa=0: clean; go to next address.
    - pa=1, s=0: bit 0 is in error; flip bit 0; sec_count++; go to WB.
    - pa=1, s in 1..CW_WIDTH-1: flip bit s; sec_count++; go to WB.
    - pa=1, s>=CW_WIDTH: treat as DED.
    - pa=0, s!=0: DED.
    - On any DED: ded_count++. If ded_flag=0, set ded_flag and capture ded_addr=addr. No write-back; go to next address.
  - WB: mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=corrected codeword; go to next address.
  - Next address: if addr=DEPTH-1 or abort was sampled high during this address, go to DONE. Otherwise addr++ and go to RD.
  - DONE: done=1 for one cycle, busy=0; go to IDLE.
- Outputs outside RD/WB: mem_en=0 and mem_we=0; mem_wdata holds its last value.
- Timing: a clean address costs 3 cycles (RD, WAIT, CHK) and a corrected address costs 4. A fully clean pass of DEPTH=8 gives done 25 cycles after the start pulse is sampled.
- Counters saturate at 2**CNT_WIDTH-1 and do not wrap. Counter values hold after done until the next start.
- The address does not wrap within a pass; the pass always ends at DEPTH-1.
- start and abort asserted in the same cycle in IDLE: start wins and abort is ignored.
- start while busy is ignored.

Test Plan:
- All 8 addresses preloaded with 13'h144E (data 8'hA5), start -> 8 reads, no writes; done 25 cycles after start; sec=0, ded=0, ded_flag=0.
- Address 2 holds 13'h140E (position 6 flipped) -> exactly one write, addr=2, wdata=13'h144E; sec=1; a second pass finds no errors.
- Address 5 holds 13'h144F (parity bit 0 flipped) -> write-back 13'h144E; sec=1.
- Address 3 holds 13'h100E (positions 6 and 10 flipped), address 6 holds 13'h100E -> no writes; ded=2, ded_flag=1, ded_addr=3; RAM contents unchanged.
- abort pulsed during address 1 -> done after address 1 finishes; addresses 2..7 never read; busy falls with done.
- rst asserted during WB of address 4 -> all outputs 0 at once, mem_we=0, FSM in IDLE; a new start restarts from address 0 with counters cleared.
